// File: rtl/lpdiv.sv
// ============================================================================
// lpdiv : iterative 8-bit restoring divider, signed/unsigned with saturation
// Revision: 1.0
// ============================================================================
`default_nettype none

package sparrow;
    localparam int VLEN = 8;
endpackage

module lpdiv #(
    parameter int VLEN = sparrow::VLEN
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [VLEN-1:0]     opA,
    input  logic [VLEN-1:0]     opB,
    input  logic                sign,
    input  logic                sat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*VLEN-1:0]   div_res,
    output logic                dz,
    output logic                ovf
);

    localparam int CW = $clog2(VLEN);
    localparam logic [VLEN-1:0] C_SMIN = {1'b1, {(VLEN-1){1'b0}}};
    localparam logic [VLEN-1:0] C_SMAX = {1'b0, {(VLEN-1){1'b1}}};
    localparam logic [VLEN-1:0] C_ONES = {VLEN{1'b1}};
    localparam logic [CW-1:0]   C_CNT_TOP = CW'(VLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [VLEN-1:0]     q_q, q_d;
    logic [VLEN-1:0]     r_q, r_d;
    logic [VLEN-1:0]     b_q, b_d;
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;
    logic [2*VLEN-1:0]   res_q, res_d;
    logic                dz_q, dz_d;
    logic                ovf_q, ovf_d;

    logic [VLEN-1:0]     w_abs_a;
    logic [VLEN-1:0]     w_abs_b;
    logic                w_is_dz;
    logic                w_is_ovf;
    logic [VLEN-1:0]     w_dz_quot;
    logic [VLEN:0]       w_r_sh;
    logic                w_ge;

    // |-128| wraps to 0x80, which is exactly the unsigned magnitude we want
    assign w_abs_a  = (sign & opA[VLEN-1]) ? -opA : opA;
    assign w_abs_b  = (sign & opB[VLEN-1]) ? -opB : opB;
    assign w_is_dz  = (opB == '0);
    assign w_is_ovf = sign & (opA == C_SMIN) & (opB == C_ONES);
    assign w_dz_quot = (sign & sat) ? (opA[VLEN-1] ? C_SMIN : C_SMAX) : C_ONES;

    // The shifted partial remainder carries the extra bit, so the stored
    // remainder never needs more than VLEN bits.
    assign w_r_sh = {r_q, q_q[VLEN-1]};
    assign w_ge   = (w_r_sh >= {1'b0, b_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        b_d     = b_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        res_d   = res_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    negq_d = sign & (opA[VLEN-1] ^ opB[VLEN-1]);
                    negr_d = sign & opA[VLEN-1];
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                    q_d    = w_abs_a;
                    b_d    = w_abs_b;
                    r_d    = '0;
                    cnt_d  = C_CNT_TOP;
                    if (w_is_dz) begin
                        dz_d    = 1'b1;
                        res_d   = {opA, w_dz_quot};
                        state_d = S_DONE;
                    end else if (w_is_ovf) begin
                        ovf_d   = 1'b1;
                        res_d   = {{VLEN{1'b0}}, (sat ? C_SMAX : C_SMIN)};
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                q_d = {q_q[VLEN-2:0], w_ge};
                r_d = w_ge ? (w_r_sh[VLEN-1:0] - b_q) : w_r_sh[VLEN-1:0];
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                res_d   = {(negr_q ? -r_q : r_q), (negq_q ? -q_q : q_q)};
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            b_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            b_q     <= b_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign div_res   = res_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lpdiv.sv
// ============================================================================
// tb_lpdiv : scoreboard bench for lpdiv (arith, special cases, backpressure)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lpdiv;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  opA = '0;
    logic [7:0]  opB = '0;
    logic        sign = 1'b0;
    logic        sat = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] div_res;
    logic        dz;
    logic        ovf;

    lpdiv dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .sign      (sign),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .div_res   (div_res),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        dz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic s, logic t);
        exp_t        e;
        logic [31:0] qv;
        logic [31:0] rv;
        int          ai;
        int          bi;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.lat = 10;
        if (b == 8'h00) begin
            e.dz  = 1'b1;
            e.lat = 1;
            qv = (s && t) ? (a[7] ? 32'h80 : 32'h7F) : 32'hFF;
            rv = {24'h0, a};
        end else if (s && a == 8'h80 && b == 8'hFF) begin
            e.ovf = 1'b1;
            e.lat = 1;
            qv = t ? 32'h7F : 32'h80;
            rv = 32'h0;
        end else if (s) begin
            ai = $signed(a);
            bi = $signed(b);
            qv = ai / bi;
            rv = ai % bi;
        end else begin
            ai = {24'h0, a};
            bi = {24'h0, b};
            qv = ai / bi;
            rv = ai % bi;
        end
        e.res = {rv[7:0], qv[7:0]};
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic t, input bit push);
        int w;
        if (push) sb.push_back(model(a, b, s, t));
        opA = a; opB = b; sign = s; sat = t;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready) begin
            @(negedge clk);
            w++;
            if (w > 50) begin
                $display("FAIL issue_timeout: in_ready stuck at %b, required 1", in_ready);
                $fatal(1, "in_ready never asserted");
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_res !== 16'h0 ||
            dz !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got rdy=%b vld=%b res=%h dz=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, div_res, dz, ovf);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        logic [7:0] ta [8] = '{8'd200, 8'hF9, 8'h07, 8'h80, 8'h80, 8'hFF, 8'h81, 8'h05};
        logic [7:0] tb [8] = '{8'd7,   8'h02, 8'hFE, 8'hFF, 8'h03, 8'h10, 8'h81, 8'h09};
        logic       ts [8] = '{1'b0,   1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        exp_t e;
        int   lat;
        for (int i = 0; i < 8; i++) begin
            issue(ta[i], tb[i], ts[i], 1'b1, 1'b1);
            wait_result(lat);
            e = sb.pop_front();
            n_cmp++;
            if (div_res !== e.res || dz !== e.dz || ovf !== e.ovf || lat != e.lat) begin
                n_err++;
                $display("FAIL arith %h/%h s=%b: got res=%h dz=%b ovf=%b lat=%0d, want res=%h dz=%b ovf=%b lat=%0d",
                         ta[i], tb[i], ts[i], div_res, dz, ovf, lat, e.res, e.dz, e.ovf, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_special();
        logic [7:0] ta [6] = '{8'h85, 8'h85, 8'h85, 8'h05, 8'h80, 8'h80};
        logic [7:0] tb [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        logic       ts [6] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
        logic       tt [6] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
        exp_t e;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i], ts[i], tt[i], 1'b1);
            wait_result(lat);
            e = sb.pop_front();
            n_cmp++;
            if (div_res !== e.res || dz !== e.dz || ovf !== e.ovf || lat != e.lat) begin
                n_err++;
                $display("FAIL special %h/%h s=%b sat=%b: got res=%h dz=%b ovf=%b lat=%0d, want res=%h dz=%b ovf=%b lat=%0d",
                         ta[i], tb[i], ts[i], tt[i], div_res, dz, ovf, lat, e.res, e.dz, e.ovf, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        int          lat;
        logic [15:0] snap;
        issue(8'd200, 8'd7, 1'b0, 1'b0, 1'b1);
        wait_result(lat);
        e = sb.pop_front();
        n_cmp++;
        if (div_res !== e.res || lat != e.lat) begin
            n_err++;
            $display("FAIL bp_first: got res=%h lat=%0d, want res=%h lat=%0d", div_res, lat, e.res, e.lat);
        end
        snap = div_res;
        opA = 8'd100; opB = 8'd10; sign = 1'b0; sat = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (div_res !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc %0d: got res=%h vld=%b rdy=%b, want res=%h vld=1 rdy=0",
                         i, div_res, out_valid, in_ready, snap);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
        sb.push_back(model(8'd100, 8'd10, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: got rdy=%b, want 0", in_ready);
        end
        wait_result(lat);
        e = sb.pop_front();
        n_cmp++;
        if (div_res !== e.res || lat != e.lat) begin
            n_err++;
            $display("FAIL bp_next: got res=%h lat=%0d, want res=%h lat=%0d", div_res, lat, e.res, e.lat);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        issue(8'd200, 8'd7, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_res !== 16'h0 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got rdy=%b vld=%b res=%h dz=%b, want 1 0 0000 0",
                     in_ready, out_valid, div_res, dz);
        end
        rstn = 1'b1;
        @(negedge clk);
        issue(8'd100, 8'd10, 1'b0, 1'b0, 1'b1);
        wait_result(lat);
        e = sb.pop_front();
        n_cmp++;
        if (div_res !== e.res || div_res !== 16'h000A || lat != e.lat) begin
            n_err++;
            $display("FAIL reset_mid_fresh: got res=%h lat=%0d, want res=%h lat=%0d", div_res, lat, e.res, e.lat);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        int         lat;
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic       t;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom);
            b = (i % 6 == 5) ? 8'h00 : 8'($urandom);
            s = 1'($urandom);
            t = 1'($urandom);
            issue(a, b, s, t, 1'b1);
            wait_result(lat);
            e = sb.pop_front();
            n_cmp++;
            if (div_res !== e.res || dz !== e.dz || ovf !== e.ovf || lat != e.lat) begin
                n_err++;
                $display("FAIL b2b %h/%h s=%b sat=%b: got res=%h dz=%b ovf=%b lat=%0d, want res=%h dz=%b ovf=%b lat=%0d",
                         a, b, s, t, div_res, dz, ovf, lat, e.res, e.dz, e.ovf, e.lat);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            consume();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_arith();
        test_special();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
